drv_led_pattern_gen: RTL
========================

Name: drv_led_pattern_gen

Overview:
- Upstream stage of the drive present/LED pin controller. Converts per-drive LED mode codes into the AMBER_DAT/BLUE_DAT level buses that the pin controller drives onto the shared present/LED pins.
- Mode codes are written by the BMC register interface.
- Holds a 36-entry mode register file, a common blink timebase and per-drive output gating against the debounced PRSNT vector.
- All drives share one blink phase, so they blink in unison.

Parameters:
- NUM_DRV, 36, number of drive slots.
- CLK_FREQ_HZ, 25_000_000, SYSCLK frequency. Used to derive the 125 ms tick.
- LED_ACTIVE_LOW, 1, 1 = LED lit when the DAT bit is 0.

Ports:
- SYSCLK  in  1  system clock.
- RESET_N  in  1  reset, asynchronous, active-low. Clock is SYSCLK.
- WR_EN  in  1  single-cycle write strobe.
- WR_ADDR  in  6  drive index for the write.
- WR_DATA  in  4  [3:2] amber code, [1:0] blue code.
- RD_ADDR  in  6  drive index for readback.
- RD_DATA  out  4  registered readback of the mode entry.
- PRSNT  in  NUM_DRV  drive present, 1 = present.
- LAMP_TEST  in  1  force all LEDs lit.
- AMBER_DAT  out  NUM_DRV  amber pin data level.
- BLUE_DAT  out  NUM_DRV  blue pin data level.
- TICK_125MS  out  1  one-cycle pulse every 125 ms (debug/test).

Behaviour:
- Mode codes, 2 bits each: 0 = OFF, 1 = ON, 2 = SLOW (1 Hz, 500 ms on / 500 ms off), 3 = FAST (4 Hz, 125 ms on / 125 ms off).
- Reset values:
  - mode file all 0.
  - RD_DATA = 0.
  - TICK_125MS = 0.
  - prescaler = 0, phase = 0.
  - AMBER_DAT and BLUE_DAT = all-inactive level: all 1s if LED_ACTIVE_LOW, else all 0s.
- Prescaler:
  - counts 0..TICK_MAX, where TICK_MAX = CLK_FREQ_HZ/8 - 1; width = clog2(TICK_MAX+1).
  - At TICK_MAX it wraps to 0 and asserts TICK_125MS for exactly that one cycle.
- Phase counter:
  - 3-bit, increments on each tick, wraps 7 -> 0.
  - fast_on = phase[0]; slow_on = phase[2].
- Writes:
  - When WR_EN=1 and WR_ADDR < NUM_DRV, entry[WR_ADDR] <= WR_DATA on that edge.
  - WR_ADDR >= NUM_DRV is ignored; no entry changes.
  - A write never resets the prescaler or phase. A new blink mode joins the global phase immediately.
- Readback:
  - RD_DATA <= entry[RD_ADDR] (1-cycle latency).
  - RD_ADDR >= NUM_DRV returns 0.
  - Simultaneous write and read of the same index returns the old value; the new value appears on the next read cycle.
- Per drive i, lit_amber is computed as:
  - 1 if LAMP_TEST=1 (regardless of PRSNT);
  - otherwise 0 if PRSNT[i]=0;
  - otherwise decode(amber code, fast_on, slow_on).
  - lit_blue is computed the same way from the blue code.
- Output registers:
  - AMBER_DAT[i] <= lit_amber XOR LED_ACTIVE_LOW; BLUE_DAT[i] is built the same way.
  - Latency is 1 SYSCLK from a mode write, PRSNT change, LAMP_TEST change or phase change to the output.
- Tick and write on the same cycle: the output computed on that edge uses the old phase and old mode. Both updates are visible on the following edge.
- Reset mid-blink: all state clears asynchronously and outputs go inactive immediately. After RESET_N deasserts, blinking restarts from phase 0, which is LED off for the first 125 ms for FAST and 500 ms for SLOW.
- PRSNT loss mid-blink: the output goes inactive 1 cycle later. The mode entry is kept, so LED behaviour resumes when the drive is reinserted.

Decomposition:
- Shared package (baseboard_led_pkg): LED mode code constants (LED_OFF, LED_ON, LED_SLOW, LED_FAST), the mode-field bit positions in WR_DATA, and the TICK_MAX derivation function.
- One sub-module: led_blink_timebase (prescaler + 3-bit phase). Outputs are tick, fast_on and slow_on. It is reusable by other LED blocks on the board.
- Decode and gating stay inline in a generate loop over NUM_DRV.

Test Plan:
- All tests use CLK_FREQ_HZ=800, so TICK_MAX=99.
- Reset test: hold RESET_N=0 -> AMBER_DAT=BLUE_DAT=36'hF_FFFF_FFFF, RD_DATA=0, TICK_125MS=0. After release, the first TICK_125MS occurs 100 cycles later and repeats every 100 cycles.
- Static modes: PRSNT=all 1s, write drive 5 = 4'b0100 (amber ON, blue OFF) -> the next edge gives AMBER_DAT[5]=0 and BLUE_DAT[5]=1. Read RD_ADDR=5 -> RD_DATA=4'h4 one cycle later.
- Blink timing: drive 0 blue FAST, drive 1 blue SLOW -> BLUE_DAT[0] toggles every 100 cycles. BLUE_DAT[1] is high for 400 cycles, then low for 400 cycles. Both toggles land 1 cycle after TICK_125MS. Writing another drive mid-period does not shift the phase.
- Presence gating: drive 7 amber ON, then drop PRSNT[7] -> AMBER_DAT[7]=1 one cycle later. Reassert PRSNT[7] -> AMBER_DAT[7]=0 one cycle later, with no rewrite needed.
- Lamp test: PRSNT=0, all modes OFF, LAMP_TEST=1 -> all AMBER_DAT and BLUE_DAT bits are 0 next cycle. Deassert LAMP_TEST -> all bits return to 1.
- Address boundary and collision:
  - WR_EN with WR_ADDR=36, data 4'hF -> no entry changes; RD_ADDR=36 returns 0.
  - Same-cycle write and read of drive 35 returns the old value; the next read returns 4'hF.
  - Assert RESET_N=0 mid-SLOW -> outputs are inactive immediately.

Source files
------------

// File: rtl/baseboard_led_pkg.sv
// Shared LED definitions for baseboard LED blocks: mode codes, the mode-field
// layout inside a write word, and the blink timebase derivation.
package baseboard_led_pkg;

  // Two-bit LED mode codes
  localparam logic [1:0] LED_OFF  = 2'd0;
  localparam logic [1:0] LED_ON   = 2'd1;
  localparam logic [1:0] LED_SLOW = 2'd2;  // 1 Hz, 500 ms on / 500 ms off
  localparam logic [1:0] LED_FAST = 2'd3;  // 4 Hz, 125 ms on / 125 ms off

  // Mode word layout: [3:2] amber code, [1:0] blue code
  localparam int MODE_W    = 4;
  localparam int ADDR_W    = 6;
  localparam int AMBER_MSB = 3;
  localparam int AMBER_LSB = 2;
  localparam int BLUE_MSB  = 1;
  localparam int BLUE_LSB  = 0;

  // Last prescaler count of a 125 ms period (eight ticks per second)
  function automatic int unsigned tick_max(input int unsigned clk_freq_hz);
    return clk_freq_hz / 8 - 1;
  endfunction

  // Lit state of one LED for a mode code and the shared blink phase
  function automatic logic led_decode(input logic [1:0] code,
                                      input logic       fast_on,
                                      input logic       slow_on);
    case (code)
      LED_ON:   return 1'b1;
      LED_SLOW: return slow_on;
      LED_FAST: return fast_on;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/led_blink_timebase.sv
// Common blink timebase: a 125 ms prescaler and a 3-bit phase counter.
// phase[0] toggles every 125 ms (FAST), phase[2] every 500 ms (SLOW).
module led_blink_timebase
  import baseboard_led_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 25_000_000
) (
  input  logic SYSCLK,
  input  logic RESET_N,
  output logic tick_o,
  output logic fast_on_o,
  output logic slow_on_o
);

  localparam int unsigned TICK_MAX = tick_max(CLK_FREQ_HZ);
  localparam int unsigned CNT_W    = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;

  logic [CNT_W-1:0] presc_q, presc_d;
  logic [2:0]       phase_q, phase_d;

  // The tick is the wrap cycle of the prescaler itself, so it is one cycle wide
  assign tick_o    = (presc_q == CNT_W'(TICK_MAX));
  assign fast_on_o = phase_q[0];
  assign slow_on_o = phase_q[2];

  // Next prescaler count and phase; phase wraps 7 -> 0 by natural overflow
  always_comb begin
    presc_d = tick_o ? '0 : presc_q + 1'b1;
    phase_d = tick_o ? phase_q + 3'd1 : phase_q;
  end

  // Prescaler and phase registers
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!RESET_N) begin
      presc_q <= '0;
      phase_q <= '0;
    end else begin
      presc_q <= presc_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/drv_led_pattern_gen.sv
// Per-drive LED pattern generator: mode register file, shared blink timebase,
// presence gating and lamp test, producing registered AMBER/BLUE pin levels.
module drv_led_pattern_gen
  import baseboard_led_pkg::*;
#(
  parameter int unsigned NUM_DRV        = 36,
  parameter int unsigned CLK_FREQ_HZ    = 25_000_000,
  parameter bit          LED_ACTIVE_LOW = 1'b1
) (
  input  logic               SYSCLK,
  input  logic               RESET_N,
  input  logic               WR_EN,
  input  logic [ADDR_W-1:0]  WR_ADDR,
  input  logic [MODE_W-1:0]  WR_DATA,
  input  logic [ADDR_W-1:0]  RD_ADDR,
  output logic [MODE_W-1:0]  RD_DATA,
  input  logic [NUM_DRV-1:0] PRSNT,
  input  logic               LAMP_TEST,
  output logic [NUM_DRV-1:0] AMBER_DAT,
  output logic [NUM_DRV-1:0] BLUE_DAT,
  output logic               TICK_125MS
);

  // Pin level of an unlit LED on every drive
  localparam logic [NUM_DRV-1:0] INACTIVE = {NUM_DRV{LED_ACTIVE_LOW}};

  logic [MODE_W-1:0]  mode_q [NUM_DRV];
  logic [MODE_W-1:0]  rd_data_q, rd_data_d;
  logic [NUM_DRV-1:0] lit_amber, lit_blue;
  logic [NUM_DRV-1:0] amber_q, amber_d, blue_q, blue_d;
  logic               tick, fast_on, slow_on;

  led_blink_timebase #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ)
  ) u_timebase (
    .SYSCLK    (SYSCLK),
    .RESET_N   (RESET_N),
    .tick_o    (tick),
    .fast_on_o (fast_on),
    .slow_on_o (slow_on)
  );

  // Mode register file; out-of-range write addresses match no entry
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      // NOTE: the mode file must read back as all OFF after reset, so it is built
      // from resettable flops rather than an unreset RAM.
      for (int i = 0; i < NUM_DRV; i++) mode_q[i] <= '0;
    end else if (WR_EN) begin
      for (int i = 0; i < NUM_DRV; i++) begin
        if (WR_ADDR == ADDR_W'(i)) mode_q[i] <= WR_DATA;
      end
    end
  end

  // Readback select; out-of-range addresses read as zero
  always_comb begin
    // NOTE: default first so every path assigns rd_data_d and no latch is inferred.
    rd_data_d = '0;
    for (int i = 0; i < NUM_DRV; i++) begin
      if (RD_ADDR == ADDR_W'(i)) rd_data_d = mode_q[i];
    end
  end

  // Per-drive decode with lamp-test override and presence gating
  for (genvar g = 0; g < NUM_DRV; g++) begin : g_drv
    logic [1:0] amber_code, blue_code;
    assign amber_code   = mode_q[g][AMBER_MSB:AMBER_LSB];
    assign blue_code    = mode_q[g][BLUE_MSB:BLUE_LSB];
    assign lit_amber[g] = LAMP_TEST | (PRSNT[g] & led_decode(amber_code, fast_on, slow_on));
    assign lit_blue[g]  = LAMP_TEST | (PRSNT[g] & led_decode(blue_code, fast_on, slow_on));
  end

  // Convert lit state to pin polarity
  always_comb begin
    amber_d = lit_amber ^ INACTIVE;
    blue_d  = lit_blue ^ INACTIVE;
  end

  // Readback and pin output registers; old mode value wins on a same-cycle write
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rd_data_q <= '0;
      amber_q   <= INACTIVE;
      blue_q    <= INACTIVE;
    end else begin
      rd_data_q <= rd_data_d;
      amber_q   <= amber_d;
      blue_q    <= blue_d;
    end
  end

  assign RD_DATA    = rd_data_q;
  assign AMBER_DAT  = amber_q;
  assign BLUE_DAT   = blue_q;
  assign TICK_125MS = tick;

endmodule
